// File: rtl/sdram_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_wb_arbiter
//  Description : Round-robin Wishbone arbiter sharing the sdram_top slave port
//                between NM masters, with a per-beat ack watchdog.
//  Revision    : 1.0
// ============================================================================
module sdram_wb_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM*AW-1:0] m_address,
    input  logic [NM*DW-1:0] m_writedata,
    input  logic [NM-1:0]    m_write,
    input  logic [NM-1:0]    m_strobe,
    input  logic [NM-1:0]    m_cycle,
    output logic [DW-1:0]    m_readdata,
    output logic [NM-1:0]    m_ack,
    output logic [NM-1:0]    m_err,
    output logic [AW-1:0]    s_address,
    output logic [DW-1:0]    s_writedata,
    output logic             s_write,
    output logic             s_strobe,
    output logic             s_cycle,
    input  logic [DW-1:0]    s_readdata,
    input  logic             s_ack,
    output logic [NM-1:0]    grant,
    output logic [7:0]       err_count
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_ERR       = 2'd2,
        ST_WAIT_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [7:0]      err_count_q, err_count_d;

    logic [NM-1:0]   req;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     idx;

    assign req        = m_cycle & m_strobe;
    assign m_readdata = s_readdata;
    assign grant      = grant_q;
    assign err_count  = err_count_q;

    // Scan from the farthest slot down so the nearest requester after last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int k = NM; k >= 1; k--) begin
            idx = {1'b0, last_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NM)) begin
                idx = idx - (IW+1)'(NM);
            end
            if (req[idx[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = idx[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            last_q      <= IW'(NM-1);
            wd_cnt_q    <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wd_cnt_q    <= wd_cnt_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wd_cnt_d    = '0;
        err_count_d = err_count_q;
        s_cycle     = 1'b0;
        s_strobe    = 1'b0;
        s_write     = 1'b0;
        s_address   = '0;
        s_writedata = '0;
        m_ack       = '0;
        m_err       = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = {{(NM-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                s_cycle     = m_cycle[owner_q];
                s_strobe    = m_strobe[owner_q];
                s_write     = m_write[owner_q];
                s_address   = m_address[int'(owner_q)*AW +: AW];
                s_writedata = m_writedata[int'(owner_q)*DW +: DW];
                m_ack       = grant_q & {NM{s_ack}};
                if (!m_cycle[owner_q]) begin
                    last_d  = owner_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (m_strobe[owner_q] && !s_ack) begin
                    // An ack in the final watchdog cycle falls outside this branch and wins.
                    if (wd_cnt_q == WW'(TIMEOUT-1)) begin
                        state_d = ST_ERR;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            ST_ERR: begin
                m_err       = grant_q;
                err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
                state_d     = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (!m_cycle[owner_q]) begin
                    last_d  = owner_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single SDRAM access slave port of sdram_top between NM masters, e.g. audio sample streamer, DMA and CPU.
- Grant is held for a whole Wishbone cycle, i.e. while CYC stays high, so block transfers are atomic.
- Per-beat ack watchdog: a beat that is never acknowledged is terminated with ERR to the owning master, then the bus is released.
- Sits between the masters' interconnect and the wbs_sdram_* port of sdram_top.

Parameters:
- NM, 2, number of masters (2..4).
- AW, 32, address width.
- DW, 16, data width.
- TIMEOUT, 1024, cycles a strobed beat may wait for ack before ERR (>=4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- m_address  in  NM*AW  packed master addresses; master i occupies bits [i*AW +: AW].
- m_writedata  in  NM*DW  packed master write data.
- m_write  in  NM  per-master write enable.
- m_strobe  in  NM  per-master STB.
- m_cycle  in  NM  per-master CYC.
- m_readdata  out  DW  read data, broadcast to all masters.
- m_ack  out  NM  per-master ACK.
- m_err  out  NM  per-master ERR, single-cycle pulse.
- s_address  out  AW  to wbs_sdram_address.
- s_writedata  out  DW  to wbs_sdram_writedata.
- s_write  out  1  to wbs_sdram_write.
- s_strobe  out  1  to wbs_sdram_strobe.
- s_cycle  out  1  to wbs_sdram_cycle.
- s_readdata  in  DW  from wbs_sdram_readdata.
- s_ack  in  1  from wbs_sdram_ack.
- grant  out  NM  one-hot current owner; 0 when idle.
- err_count  out  8  saturating count of timeouts.

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; grant=0; last=NM-1, so master 0 has first priority.
  - wd_cnt=0; err_count=0.
  - s_cycle, s_strobe, s_write, m_ack, m_err all 0; s_address and s_writedata 0.
  - Reset mid-transfer aborts immediately: the slave sees CYC drop asynchronously, and no ack or err reaches any master.
- Request: master i requests when m_cycle[i] & m_strobe[i].
- IDLE:
  - If any request is present, pick the first requester scanning last+1, last+2, … modulo NM.
  - Register grant at the next edge and go to BUSY.
  - Arbitration latency is exactly 1 cycle from request to s_cycle/s_strobe assertion.
- BUSY, owner g:
  - s_cycle = m_cycle[g].
  - s_strobe = m_strobe[g].
  - s_address, s_writedata and s_write are muxed combinationally from master g.
  - m_ack[g] = s_ack (combinational); m_ack of every other master is 0.
  - m_readdata = s_readdata at all times.
  - Strobe changes within the cycle do not release the grant.
  - When m_cycle[g] is 0 at an edge: last=g, grant=0, go to IDLE.
  - There is always at least one idle cycle between owners, so two grants are never back-to-back.
- Watchdog:
  - wd_cnt increments every BUSY cycle with s_strobe & ~s_ack.
  - wd_cnt clears on s_ack, on strobe low, and on leaving BUSY.
  - When wd_cnt==TIMEOUT-1 with the beat still un-acked, go to ERR at the next edge.
- ERR:
  - One cycle long: m_err[g]=1; s_cycle=0; s_strobe=0.
  - err_count increments, saturating at 255.
  - Next state WAIT_DROP.
- WAIT_DROP:
  - s_cycle=0, s_strobe=0, m_ack=0.
  - Wait until m_cycle[g]==0, then last=g, grant=0, go to IDLE.
- Simultaneous events:
  - An ack arriving in the same cycle wd_cnt reaches TIMEOUT-1 wins: the ack is forwarded and there is no error.
  - A new request arriving while another master owns the bus waits; it is never dropped.
- Fairness: with all NM masters continuously requesting, each is granted once per NM grants.
- Non-owner masters: m_ack and m_err are always 0.

Test Plan:
- Single master, NM=2, TIMEOUT=16:
  - Stimulus: master 0 writes addr 0x100, data 0xA5A5.
  - Required: s_cycle rises 1 cycle after request with s_address=0x100 and s_writedata=0xA5A5; m_ack[0] is coincident with s_ack; grant returns to 0 one cycle after m_cycle[0] falls.
- Contention, round-robin:
  - Stimulus: both masters request together from reset, each doing 3 back-to-back single-beat cycles.
  - Required: grant order is 01,10,01,10,01,10 with exactly one idle cycle between grants.
- Block hold:
  - Stimulus: master 1 holds CYC for a 4-beat read with STB toggling; master 0 requests in the middle.
  - Required: master 0 is not granted until master 1 drops CYC; master 1 receives all 4 acks.
- Timeout:
  - Stimulus: slave never acks master 0's strobe.
  - Required: m_err[0] pulses for one cycle 16 cycles after strobe; s_cycle goes 0; err_count=1.
  - Required: the bus stays unowned until m_cycle[0] falls, after which master 1 is granted.
- Ack/timeout race:
  - Stimulus: s_ack arrives exactly in the cycle wd_cnt==15.
  - Required: m_ack[0]=1, m_err=0, err_count unchanged.
- Reset mid-transfer:
  - Stimulus: assert reset (0) asynchronously during BUSY.
  - Required: s_cycle, s_strobe and grant go to 0 without a clock edge; err_count=0.
  - Required: after release, master 0 has first priority.
